signed_alu_seq: RTL
===================

# signed_alu_seq

Parametrised, handshaked successor to the combinational 32-bit signed ALU. Same 4-bit opcode map and flag set (zf, cf, nf, of). Adds:
- registered results with valid/ready flow control on both sides;
- an iterative shift-add multiplier;
- an optional iterative signed divider.

Sits between the operand/issue stage and writeback. Holds one operation in flight at a time.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- SHW, $clog2(WIDTH), localparam; shift-amount width taken from b[SHW-1:0].
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/opcode present.
- in_ready  out  1  block can accept; equals (state==IDLE) | (state==DONE & out_ready).
- a, b  in  WIDTH  signed operands.
- sel  in  4  opcode.
- out_valid  out  1  result registered and stable.
- out_ready  in  1  consumer takes result.
- out  out  WIDTH  signed result.
- out_m  out  2*WIDTH  full product for mul; sign-extended out for every other op.
- zf, cf, nf, of  out  1 each  zero, carry/borrow, negative, signed overflow.

## Operation
- Accept on the edge where in_valid & in_ready. Latch a, b and sel internally. Input changes after accept are ignored.
- Opcodes:
  - 0000 and; 0001 or; 0010 xor; 0011 not a.
  - 0100 add; 0101 sub.
  - 0110 mul; 0111 arithmetic shift right; 1000 shift left.
  - 1001 lt (a<b); 1010 eq; 1011 gt. Compare result is 1 or 0.
  - 1100 div; 1101 rem. Available only with ALU_DIV_EN.
  - All other codes: out=0, all flags 0.
- Flags for arithmetic and logic ops:
  - zf = (out_m==0).
  - nf = out_m MSB. nf is 0 for compares.
  - cf: add = unsigned carry out of bit WIDTH-1; sub = borrow (unsigned a<b). cf is 0 for all other ops.
  - of: add/sub = signed overflow; mul = product does not fit in WIDTH signed bits; div = divide-by-zero or MIN/-1. of is 0 otherwise.
- Arithmetic:
  - Results wrap modulo 2^WIDTH.
  - mul is shift-add over |a|, |b| with a final sign fix, one bit per cycle.
  - div is restoring division on magnitudes; quotient truncates toward zero and the remainder takes the sign of a.
  - Divide-by-zero: quotient = all ones, remainder = a, of=1.
  - MIN/-1: quotient = MIN, remainder = 0, of=1.
  - Shift amounts ≥ WIDTH cannot occur (only SHW bits are used). asr fills with the sign bit; shl fills with zeros.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE→DONE for single-cycle ops.
  - IDLE→MUL or IDLE→DIV on accept of 0110 or 1100/1101.
  - MUL→DONE when the iteration counter reaches WIDTH-1.
  - DIV→DONE after WIDTH iterations plus one sign-fix cycle.
  - DONE→IDLE on out_ready with no new accept. DONE→(next state) on out_ready with a simultaneous accept.

## Timing
- Reset values: out=0, out_m=0, all flags 0, out_valid=0, state=IDLE, so in_ready=1.
- Latency from the accepting edge N:
  - single-cycle ops: out_valid at N+1;
  - mul: out_valid at N+WIDTH;
  - div/rem: out_valid at N+WIDTH+1.
- out, out_m and flags hold stable while out_valid & !out_ready.
- Back-to-back issue: in DONE with out_ready=1, a new accept on the same edge retires the old result. out_valid stays high only if the new op is single-cycle; otherwise it drops until that op completes.
- Reset asserted mid-operation aborts immediately. Outputs go to reset values and the partial result is discarded.

## Configuration
- ALU_DIV_EN defined: divider datapath, DIV state and opcodes 1100/1101 are compiled in.
- ALU_DIV_EN undefined: 1100/1101 decode as the default op (out=0, flags 0, 1-cycle). The DIV state and its registers are absent.

## Structure
- Shared package signed_alu_pkg holds:
  - opcode localparams OP_AND…OP_REM;
  - the FSM state enum;
  - flag index constants.
- One sub-module, alu_seq_muldiv, contains the iterative mul/div datapath with start/done/busy signals. The top level holds the FSM, handshake, single-cycle ops and flag logic.

## Test plan
- Reset, then release: out=0, out_m=0, all flags 0, out_valid=0, in_ready=1. Also assert rst_n mid-mul at cycle N+5: outputs zero immediately and no out_valid follows.
- Add 1973741829+1973741829 (sel 0100): out=-347483638, of=1, nf=1, cf=0, zf=0, out_valid at N+1.
- Sub 496569044-496569044 (sel 0101): out=0, zf=1, cf=0, of=0. Also sub 5-7: out=-2, cf=1, nf=1.
- Mul -3×7 with WIDTH=32: out_m=-21, nf=1, of=0, out_valid at N+32. Hold out_ready=0 for 5 cycles and check out_m stays stable. Mul 0x40000000×4: out=0, out_m=2^32, zf=0, of=1.
- Shifts and compares:
  - asr -32653565 by 31: out=-1, nf=1;
  - shl 1973741829 by 1: out=-347483638, cf=0, of=0;
  - eq -43984379,-43984379: out=1;
  - sel 1111: out=0, all flags 0;
  - back-to-back issue of 4 single-cycle ops at 1 op/cycle with out_ready=1.
- With ALU_DIV_EN:
  - div -7/2: out=-3, of=0;
  - rem -7,2: out=-1, nf=1;
  - div 5/0: out=-1, of=1.
  - Without ALU_DIV_EN, sel 1100 gives out=0 at N+1.

Source files
------------

// File: rtl/signed_alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for signed_alu_seq.
// Optional divider: compile with ALU_DIV_EN defined.
package signed_alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_NOT = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0101;
    localparam logic [3:0] OP_MUL = 4'b0110;
    localparam logic [3:0] OP_ASR = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_LT  = 4'b1001;
    localparam logic [3:0] OP_EQ  = 4'b1010;
    localparam logic [3:0] OP_GT  = 4'b1011;
    localparam logic [3:0] OP_DIV = 4'b1100;
    localparam logic [3:0] OP_REM = 4'b1101;

    localparam int FLAG_ZF = 0;
    localparam int FLAG_CF = 1;
    localparam int FLAG_NF = 2;
    localparam int FLAG_OF = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
`ifdef ALU_DIV_EN
        ST_DIV,
`endif
        ST_DONE
    } state_t;

endpackage

// File: rtl/signed_alu_seq_if.sv
// Issue/result handshake bundle between the issue stage, signed_alu_seq and writeback.
interface signed_alu_seq_if #(parameter int WIDTH = 32);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [WIDTH-1:0]   a;
    logic signed [WIDTH-1:0]   b;
    logic [3:0]                sel;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [WIDTH-1:0]   out;
    logic signed [2*WIDTH-1:0] out_m;
    logic                      zf;
    logic                      cf;
    logic                      nf;
    logic                      of;

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, out, out_m, zf, cf, nf, of
    );

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, out, out_m, zf, cf, nf, of
    );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative shift-add multiplier and (with ALU_DIV_EN) restoring divider on magnitudes.
// The first iteration runs on the start edge; o_done marks the edge that finishes.
module alu_seq_muldiv #(parameter int WIDTH = 32) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_start,
`ifdef ALU_DIV_EN
    input  logic                      i_div,
`endif
    input  logic signed [WIDTH-1:0]   i_a,
    input  logic signed [WIDTH-1:0]   i_b,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [2*WIDTH-1:0]        o_prod
`ifdef ALU_DIV_EN
    ,
    output logic [WIDTH-1:0]          o_quot,
    output logic [WIDTH-1:0]          o_rem
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   w_ua, w_ub;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic               w_mul_last;
    logic               r_busy, r_neg;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc, r_mcand;
    logic [WIDTH-1:0]   r_mplier;

    assign w_ua      = i_a[WIDTH-1] ? (~i_a + 1'b1) : i_a;
    assign w_ub      = i_b[WIDTH-1] ? (~i_b + 1'b1) : i_b;
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_prod    = r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
    assign o_busy    = r_busy;

`ifdef ALU_DIV_EN
    logic             w_div_last;
    logic             r_div, r_neg_r, r_bzero;
    logic [WIDTH-1:0] r_rem, r_quo, r_dvs;

    // One restoring step: returns {remainder, quotient-shift-register}.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] quo,
                                                    input logic [WIDTH-1:0] dvs);
        logic [WIDTH:0] sh;
        sh = {rem, quo[WIDTH-1]};
        if (sh >= {1'b0, dvs})
            return {sh[WIDTH-1:0] - dvs, quo[WIDTH-2:0], 1'b1};
        return {sh[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    endfunction

    assign w_mul_last = r_busy & ~r_div & (r_cnt == CW'(WIDTH - 1));
    assign w_div_last = r_busy &  r_div & (r_cnt == CW'(WIDTH));
    assign o_done     = w_mul_last | w_div_last;
    assign o_quot     = r_bzero ? '1 : (r_neg ? (~r_quo + 1'b1) : r_quo);
    assign o_rem      = r_neg_r ? (~r_rem + 1'b1) : r_rem;
`else
    assign w_mul_last = r_busy & (r_cnt == CW'(WIDTH - 1));
    assign o_done     = w_mul_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
`ifdef ALU_DIV_EN
            r_div    <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
`endif
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= CW'(1);
            r_neg    <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
            r_acc    <= w_ub[0] ? {{WIDTH{1'b0}}, w_ua} : '0;
            r_mcand  <= {{(WIDTH-1){1'b0}}, w_ua, 1'b0};
            r_mplier <= w_ub >> 1;
`ifdef ALU_DIV_EN
            r_div          <= i_div;
            r_neg_r        <= i_a[WIDTH-1];
            r_bzero        <= (i_b == '0);
            r_dvs          <= w_ub;
            {r_rem, r_quo} <= div_step('0, w_ua, w_ub);
`endif
        end else if (r_busy) begin
            if (o_done)
                r_busy <= 1'b0;
            else
                r_cnt <= r_cnt + 1'b1;
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
`ifdef ALU_DIV_EN
            // Count WIDTH is the sign-fix cycle; the magnitudes are already final.
            if (r_cnt != CW'(WIDTH))
                {r_rem, r_quo} <= div_step(r_rem, r_quo, r_dvs);
`endif
        end
    end

endmodule

// File: rtl/signed_alu_seq.sv
// Handshaked signed ALU: FSM, single-cycle ops and flags; mul/div via alu_seq_muldiv.
// Divide/remainder opcodes exist only when ALU_DIV_EN is defined.
//
// state   | meaning
// IDLE    | empty, ready to accept
// MUL     | multiplier iterating
// DIV     | divider iterating plus sign fix (ALU_DIV_EN only)
// DONE    | result registered, out_valid high until taken
module signed_alu_seq
    import signed_alu_pkg::*;
#(parameter int WIDTH = 32) (
    input  logic             clk,
    input  logic             rst_n,
    signed_alu_seq_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    state_t                  r_state;
    logic                    r_out_valid;
    logic signed [WIDTH-1:0] r_out;
    logic [2*WIDTH-1:0]      r_out_m;
    logic [3:0]              r_flags;

    logic                    w_accept, w_is_mul, w_is_div, w_md_start, w_md_busy, w_md_done;
    logic [2*WIDTH-1:0]      w_md_prod;
    logic [WIDTH:0]          w_mul_hi;
    logic [3:0]              w_mul_flags;
    logic [WIDTH:0]          w_sum, w_dif;
    logic signed [WIDTH-1:0] w_sc_out;
    logic [3:0]              w_sc_flags;
    logic                    w_sc_known, w_sc_cf, w_sc_of;

    assign bus.in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & bus.out_ready);
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.out_m     = r_out_m;
    assign bus.zf        = r_flags[FLAG_ZF];
    assign bus.cf        = r_flags[FLAG_CF];
    assign bus.nf        = r_flags[FLAG_NF];
    assign bus.of        = r_flags[FLAG_OF];

    assign w_accept   = bus.in_valid & bus.in_ready;
    assign w_is_mul   = (bus.sel == OP_MUL);
`ifdef ALU_DIV_EN
    assign w_is_div   = (bus.sel == OP_DIV) | (bus.sel == OP_REM);
`else
    assign w_is_div   = 1'b0;
`endif
    assign w_md_start = w_accept & (w_is_mul | w_is_div) & ~w_md_busy;

    always_comb begin
        w_sum      = {1'b0, bus.a} + {1'b0, bus.b};
        w_dif      = {1'b0, bus.a} - {1'b0, bus.b};
        w_sc_out   = '0;
        w_sc_cf    = 1'b0;
        w_sc_of    = 1'b0;
        w_sc_known = 1'b1;
        case (bus.sel)
            OP_AND: w_sc_out = bus.a & bus.b;
            OP_OR:  w_sc_out = bus.a | bus.b;
            OP_XOR: w_sc_out = bus.a ^ bus.b;
            OP_NOT: w_sc_out = ~bus.a;
            OP_ADD: begin
                w_sc_out = w_sum[WIDTH-1:0];
                w_sc_cf  = w_sum[WIDTH];
                w_sc_of  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                w_sc_out = w_dif[WIDTH-1:0];
                w_sc_cf  = w_dif[WIDTH];
                w_sc_of  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_dif[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_ASR: w_sc_out = bus.a >>> bus.b[SHW-1:0];
            OP_SHL: w_sc_out = bus.a << bus.b[SHW-1:0];
            OP_LT:  w_sc_out = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_EQ:  w_sc_out = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
            OP_GT:  w_sc_out = {{(WIDTH-1){1'b0}}, (bus.a > bus.b)};
            default: w_sc_known = 1'b0;
        endcase
        w_sc_flags          = '0;
        w_sc_flags[FLAG_ZF] = w_sc_known & (w_sc_out == '0);
        w_sc_flags[FLAG_CF] = w_sc_cf;
        w_sc_flags[FLAG_NF] = w_sc_known & w_sc_out[WIDTH-1];
        w_sc_flags[FLAG_OF] = w_sc_of;
    end

    // Product fits WIDTH signed bits when the top WIDTH+1 bits are all equal.
    assign w_mul_hi = w_md_prod[2*WIDTH-1:WIDTH-1];
    always_comb begin
        w_mul_flags          = '0;
        w_mul_flags[FLAG_ZF] = (w_md_prod == '0);
        w_mul_flags[FLAG_NF] = w_md_prod[2*WIDTH-1];
        w_mul_flags[FLAG_OF] = ~((&w_mul_hi) | ~(|w_mul_hi));
    end

`ifdef ALU_DIV_EN
    logic                    r_is_rem, r_div_ovf;
    logic [WIDTH-1:0]        w_md_quot, w_md_rem;
    logic signed [WIDTH-1:0] w_div_res;
    logic [3:0]              w_div_flags;

    assign w_div_res = r_is_rem ? w_md_rem : w_md_quot;
    always_comb begin
        w_div_flags          = '0;
        w_div_flags[FLAG_ZF] = (w_div_res == '0);
        w_div_flags[FLAG_NF] = w_div_res[WIDTH-1];
        w_div_flags[FLAG_OF] = r_div_ovf;
    end
`endif

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_md_start),
`ifdef ALU_DIV_EN
        .i_div   (w_is_div),
`endif
        .i_a     (bus.a),
        .i_b     (bus.b),
        .o_busy  (w_md_busy),
        .o_done  (w_md_done),
        .o_prod  (w_md_prod)
`ifdef ALU_DIV_EN
        ,
        .o_quot  (w_md_quot),
        .o_rem   (w_md_rem)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_m     <= '0;
            r_flags     <= '0;
`ifdef ALU_DIV_EN
            r_is_rem    <= 1'b0;
            r_div_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state     <= ST_MUL;
                            r_out_valid <= 1'b0;
`ifdef ALU_DIV_EN
                        end else if (w_is_div) begin
                            r_state     <= ST_DIV;
                            r_out_valid <= 1'b0;
                            r_is_rem    <= (bus.sel == OP_REM);
                            r_div_ovf   <= (bus.b == '0) |
                                           ((bus.a == {1'b1, {(WIDTH-1){1'b0}}}) & (&bus.b));
`endif
                        end else begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_out       <= w_sc_out;
                            r_out_m     <= {{WIDTH{w_sc_out[WIDTH-1]}}, w_sc_out};
                            r_flags     <= w_sc_flags;
                        end
                    end else if ((r_state == ST_DONE) && bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_MUL: if (w_md_done) begin
                    r_state     <= ST_DONE;
                    r_out_valid <= 1'b1;
                    r_out       <= w_md_prod[WIDTH-1:0];
                    r_out_m     <= w_md_prod;
                    r_flags     <= w_mul_flags;
                end
`ifdef ALU_DIV_EN
                ST_DIV: if (w_md_done) begin
                    r_state     <= ST_DONE;
                    r_out_valid <= 1'b1;
                    r_out       <= w_div_res;
                    r_out_m     <= {{WIDTH{w_div_res[WIDTH-1]}}, w_div_res};
                    r_flags     <= w_div_flags;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
